// File: rtl/traffic_source_gen_if.sv
// Source-side bundle for traffic_source_gen: control inputs, table config port and the
// request/data output handshake. master = the traffic source, slave = its consumer.
`timescale 1ns/1ps
interface traffic_source_gen_if #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned PAYLOAD_W = 8
);
  localparam int unsigned CFG_W  = (ADDR_W > PAYLOAD_W) ? ADDR_W : PAYLOAD_W;
  localparam int unsigned DATA_W = PAYLOAD_W + ADDR_W;

  logic              send;
  logic              busy;
  logic              restart;
  logic              cfg_we;
  logic              cfg_sel;
  logic [7:0]        cfg_addr;
  logic [CFG_W-1:0]  cfg_wdata;
  logic              req;
  logic [DATA_W-1:0] data;
  logic              done;
  logic [15:0]       sent_count;

  modport master (
    input  send, busy, restart, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output req, data, done, sent_count
  );

  modport slave (
    output send, busy, restart, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input  req, data, done, sent_count
  );
endinterface

// File: rtl/traffic_source_gen.sv
// Table-driven traffic source: sweeps dest_tab MSG_SIZE times, issuing {payload, dest} requests.
// Optional LFSR injection-rate limiter enabled by defining SRC_RATE_LIMIT_EN.
`timescale 1ns/1ps
module traffic_source_gen #(
  parameter int unsigned ID        = 0,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned PAYLOAD_W = 8,
  parameter int unsigned DESTS     = 16,
  parameter int unsigned MSG_SIZE  = 3,
  parameter int unsigned PIR       = 16,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  traffic_source_gen_if.master  bus
);
  localparam int unsigned DATA_W = PAYLOAD_W + ADDR_W;
  localparam int unsigned IDX_W  = (DESTS > 1) ? $clog2(DESTS) : 1;
  localparam int unsigned DIDX_W = (MSG_SIZE > 1) ? $clog2(MSG_SIZE) : 1;

  if (DESTS < 1 || DESTS > 256) begin : g_bad_dests
    $error("traffic_source_gen: DESTS out of range");
  end
  if (MSG_SIZE < 1 || MSG_SIZE > 256) begin : g_bad_msg_size
    $error("traffic_source_gen: MSG_SIZE out of range");
  end
  if (PIR > 255 || SEED == 8'h00) begin : g_bad_rate_cfg
    $error("traffic_source_gen: PIR must fit 8 bits and SEED must be nonzero");
  end

  typedef enum logic [2:0] {S_IDLE, S_DECIDE, S_ISSUE, S_GAP, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [DIDX_W-1:0]     dindex_q, dindex_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [ADDR_W-1:0]     dest_tab [DESTS];
  logic [PAYLOAD_W-1:0]  pay_tab  [MSG_SIZE];

  logic                  fire_c;
  logic                  last_idx_c, last_slot_c;
  logic [IDX_W-1:0]      adv_index_c;
  logic [DIDX_W-1:0]     adv_dindex_c;
  logic [ADDR_W-1:0]     cur_dest_c;
  logic [PAYLOAD_W-1:0]  cur_pay_c;
  logic                  cfg_ok_c;

`ifdef SRC_RATE_LIMIT_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so the injection pattern is state-independent
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    fire_c = (lfsr_q < 8'(PIR));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign fire_c = 1'b1;
`endif

  assign cur_dest_c = dest_tab[index_q];
  assign cur_pay_c  = pay_tab[dindex_q];

  // Slot advance: inner sweep over destinations, outer over payloads
  always_comb begin
    last_idx_c   = (index_q == IDX_W'(DESTS - 1));
    last_slot_c  = last_idx_c && (dindex_q == DIDX_W'(MSG_SIZE - 1));
    adv_index_c  = last_idx_c ? '0 : index_q + IDX_W'(1);
    adv_dindex_c = (last_idx_c && !last_slot_c) ? dindex_q + DIDX_W'(1) : dindex_q;
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    dindex_d = dindex_q;
    data_d   = data_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.restart) begin
          index_d  = '0;
          dindex_d = '0;
          done_d   = 1'b0;
        end else if (bus.send && !done_q) begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (cur_dest_c == ADDR_W'(ID)) begin
          index_d  = adv_index_c;
          dindex_d = adv_dindex_c;
          state_d  = last_slot_c ? S_DONE : S_IDLE;
          done_d   = last_slot_c;
        end else if (fire_c) begin
          data_d  = {cur_pay_c, cur_dest_c};
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!bus.busy) begin
          state_d = S_GAP;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        index_d  = adv_index_c;
        dindex_d = adv_dindex_c;
        state_d  = last_slot_c ? S_DONE : S_IDLE;
        done_d   = last_slot_c;
      end
      S_DONE: begin
        if (bus.restart) begin
          index_d  = '0;
          dindex_d = '0;
          done_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      dindex_q <= '0;
      data_q   <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      dindex_q <= dindex_d;
      data_q   <= data_d;
      req_q    <= req_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tables are configuration storage: no reset, writable only while quiescent
  assign cfg_ok_c = bus.cfg_we && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (cfg_ok_c && !bus.cfg_sel && (32'(bus.cfg_addr) < DESTS))
      dest_tab[IDX_W'(bus.cfg_addr)] <= bus.cfg_wdata[ADDR_W-1:0];
    if (cfg_ok_c && bus.cfg_sel && (32'(bus.cfg_addr) < MSG_SIZE))
      pay_tab[DIDX_W'(bus.cfg_addr)] <= bus.cfg_wdata[PAYLOAD_W-1:0];
  end

  assign bus.req        = req_q;
  assign bus.data       = data_q;
  assign bus.done       = done_q;
  assign bus.sent_count = cnt_q;

endmodule

// File: doc/traffic_source_gen.md
TRAFFIC_SOURCE_GEN -- requirements
Module: traffic_source_gen

Interface
REQ-001 SHALL have parameter ID, default 0, node id of this source; slots whose destination equals ID are skipped.
REQ-002 SHALL have parameter ADDR_W, default 4, destination address width.
REQ-003 SHALL have parameter PAYLOAD_W, default 8, payload width.
REQ-004 SHALL have parameter DESTS, default 16, destination table depth (1..256).
REQ-005 SHALL have parameter MSG_SIZE, default 3, payload table depth and number of sweeps (1..256).
REQ-006 SHALL have parameter PIR, default 16, 8-bit injection threshold.
REQ-007 SHALL have parameter SEED, default 8'hA5, nonzero LFSR seed.
REQ-008 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-009 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-010 SHALL have ports send (input, 1, enable issuing), busy (input, 1, downstream stall) and restart (input, 1, rearm after DONE).
REQ-011 SHALL have ports cfg_we (input, 1), cfg_sel (input, 1: 0=dest table, 1=payload table), cfg_addr (input, 8), cfg_wdata (input, max(ADDR_W,PAYLOAD_W)).
REQ-012 SHALL have outputs req (1), data (PAYLOAD_W+ADDR_W: payload in upper bits, destination in lower ADDR_W bits), done (1) and sent_count (16).

Function
REQ-013 SHALL implement FSM states IDLE, DECIDE, ISSUE, GAP, DONE.
REQ-014 IDLE->DECIDE when send=1 and done=0; otherwise SHALL remain in IDLE.
REQ-015 In DECIDE: if dest_tab[index]==ID, SHALL advance the slot and return to IDLE with no req; else, if the fire condition holds, SHALL load data={pay_tab[dindex], dest_tab[index]} and go to ISSUE; else SHALL return to IDLE without advancing.
REQ-016 In ISSUE: req=1 with data held stable; a transfer occurs in any cycle where req=1 and busy=0, after which the FSM SHALL go to GAP.
REQ-017 GAP SHALL last exactly one cycle with req=0, then SHALL advance the slot and go to IDLE (or DONE per REQ-018).
REQ-018 Slot advance: index+1; at index==DESTS-1, index=0 and dindex+1; at index==DESTS-1 and dindex==MSG_SIZE-1, SHALL enter DONE with done=1.
REQ-019 Latency SHALL be a minimum of 2 cycles from send high in IDLE to req high; the minimum spacing between transfers SHALL be 4 cycles.
REQ-020 sent_count SHALL increment by 1 per transfer and saturate at 16'hFFFF.
REQ-021 send falling while in ISSUE SHALL NOT drop req; the pending transfer SHALL complete.
REQ-022 restart=1 in DONE or IDLE SHALL clear index, dindex and done and enter IDLE next cycle; restart SHALL be ignored in DECIDE/ISSUE/GAP; sent_count SHALL NOT be cleared by restart.
REQ-023 cfg_we SHALL write table[cfg_addr] only in IDLE or DONE; writes in other states, and writes with cfg_addr at or beyond the table depth, SHALL be ignored; tables SHALL use the low ADDR_W or PAYLOAD_W bits of cfg_wdata.

Reset
REQ-024 With reset=0, state=IDLE, req=0, data=0, done=0, sent_count=0, index=0, dindex=0 and LFSR=SEED SHALL be set asynchronously.
REQ-025 Reset asserted during ISSUE SHALL drop req immediately, and the transfer SHALL NOT be counted.
REQ-026 Table contents SHALL NOT be affected by reset.

Configuration
REQ-027 With macro SRC_RATE_LIMIT_EN defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL step every cycle and the fire condition SHALL be lfsr < PIR.
REQ-028 Without SRC_RATE_LIMIT_EN, the fire condition SHALL be constant 1, no LFSR logic SHALL exist, and PIR SHALL be unused.

Verification
REQ-029 Bench: DESTS=4, ID=0, dest={1,2,3,0}, pay={41,42,43}, MSG_SIZE=3, busy=0, send=1, no rate limit -> 9 transfers in order (1,41),(2,41),(3,41),(1,42)..(3,43); done=1; sent_count=9.
REQ-030 Bench: busy held 1 for 5 cycles during ISSUE -> req and data stable for all 5 cycles; exactly one transfer on busy fall; GAP req=0 for 1 cycle.
REQ-031 Bench: after done, cfg writes dest[0]=2, then pulse restart -> indices cleared; first new transfer goes to dest 2; sent_count continues from 9.
REQ-032 Bench: reset low mid-ISSUE -> req=0 in the same cycle; sent_count=0; on reset release the FSM is in IDLE.
REQ-033 Bench: SRC_RATE_LIMIT_EN, PIR=0 -> req never asserts over 1000 cycles; PIR=255 -> transfers seen at rate at least 0.9 of the unlimited rate.
REQ-034 Bench: cfg_we pulsed during ISSUE -> table unchanged, verified by the subsequent transfer data.
